// File: rtl/pico16a_lcd_pkg.sv
// Shared definitions for the HD44780-style character LCD controller:
// FSM state encoding and the power-on init command table.
package pico16a_lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP_WAIT,
    INIT_LOAD,
    SETUP,
    PULSE,
    HOLD,
    EXEC_WAIT,
    IDLE
  } lcd_state_t;

  localparam int INIT_LEN   = 6;
  localparam int INIT_IDX_W = 3;

  // 8-bit bus / 2 lines, display on, clear, entry mode increment
  function automatic logic [7:0] init_cmd(input logic [INIT_IDX_W-1:0] idx);
    case (idx)
      3'd0:    return 8'h38;
      3'd1:    return 8'h38;
      3'd2:    return 8'h38;
      3'd3:    return 8'h0C;
      3'd4:    return 8'h01;
      3'd5:    return 8'h06;
      default: return 8'h00;
    endcase
  endfunction

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'd0);
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter used to time every LCD controller state;
// zero flags that the programmed interval has elapsed.
module lcd_delay_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// Write-only 8-bit character LCD controller: power-on wait, fixed init
// sequence, then host byte writes with SETUP/EN/HOLD/execution timing.
module lcd_ctrl
  import pico16a_lcd_pkg::*;
#(
  parameter int T_PWRUP     = 750000,
  parameter int T_SETUP     = 4,
  parameter int T_EN        = 25,
  parameter int T_HOLD      = 4,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       init_done,
  output logic       LCD_ON,
  output logic       LCD_BLON,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic [7:0] LCD_DATA
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = max2(max2(max2(T_PWRUP, T_SETUP), max2(T_EN, T_HOLD)),
                              max2(T_EXEC, T_EXEC_LONG));
  localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  lcd_state_t                state_q, state_d;
  logic                      pwr_armed;
  logic                      init_done_q;
  logic                      on_q;
  logic                      cmd_rs;
  logic [7:0]                cmd_data;
  logic [INIT_IDX_W-1:0]     init_idx;
  logic                      init_last;
  logic                      tmr_load;
  logic                      tmr_zero;
  logic [CNT_W-1:0]          tmr_val;

  assign init_last = (init_idx == INIT_IDX_W'(INIT_LEN - 1));

  lcd_delay_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (CLOCK_50),
    .rst_n    (RESET_N),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= PWRUP_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Each state's timer is loaded with (duration-1) on the entering edge.
  // PWRUP_WAIT is entered through reset with the counter cleared, so it
  // arms itself on its first clock with T_PWRUP-2 (T_PWRUP must be >= 2).
  always_comb begin
    state_d  = state_q;
    tmr_val  = '0;
    case (state_q)
      PWRUP_WAIT: if (pwr_armed && tmr_zero) state_d = INIT_LOAD;
      INIT_LOAD:  state_d = SETUP;
      SETUP:      if (tmr_zero) state_d = PULSE;
      PULSE:      if (tmr_zero) state_d = HOLD;
      HOLD:       if (tmr_zero) state_d = EXEC_WAIT;
      EXEC_WAIT:  if (tmr_zero) state_d = (init_done_q || init_last) ? IDLE : INIT_LOAD;
      IDLE:       if (wr_valid) state_d = SETUP;
      default:    state_d = PWRUP_WAIT;
    endcase

    tmr_load = (state_d != state_q) || (state_q == PWRUP_WAIT && !pwr_armed);
    case (state_d)
      PWRUP_WAIT: tmr_val = CNT_W'(T_PWRUP - 2);
      SETUP:      tmr_val = CNT_W'(T_SETUP - 1);
      PULSE:      tmr_val = CNT_W'(T_EN - 1);
      HOLD:       tmr_val = CNT_W'(T_HOLD - 1);
      EXEC_WAIT:  tmr_val = is_long_cmd(cmd_rs, cmd_data) ? CNT_W'(T_EXEC_LONG - 1)
                                                          : CNT_W'(T_EXEC - 1);
      default:    tmr_val = '0;
    endcase
  end

  always_comb begin
    LCD_EN   = (state_q == PULSE);
    wr_ready = (state_q == IDLE);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pwr_armed   <= 1'b0;
      init_done_q <= 1'b0;
      on_q        <= 1'b0;
      cmd_rs      <= 1'b0;
      cmd_data    <= 8'h00;
      init_idx    <= '0;
    end else begin
      on_q <= 1'b1;
      if (state_q == PWRUP_WAIT) pwr_armed <= 1'b1;

      if (state_q == IDLE && wr_valid) begin
        cmd_rs   <= wr_rs;
        cmd_data <= wr_data;
      end else if (state_q == INIT_LOAD) begin
        cmd_rs   <= 1'b0;
        cmd_data <= init_cmd(init_idx);
      end

      if (state_q == EXEC_WAIT && tmr_zero && !init_done_q) begin
        if (init_last) init_done_q <= 1'b1;
        else           init_idx    <= init_idx + 1'b1;
      end
    end
  end

  assign init_done = init_done_q;
  assign LCD_ON    = on_q;
  assign LCD_BLON  = on_q;
  assign LCD_RW    = 1'b0;
  assign LCD_RS    = cmd_rs;
  assign LCD_DATA  = cmd_data;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened timing parameters.
// Clocks are counted from the first rising edge after reset release (edge 0),
// and for writes the accepting edge is clock 1.
module tb_lcd_ctrl;

  localparam int T_PWRUP     = 20;
  localparam int T_SETUP     = 2;
  localparam int T_EN        = 4;
  localparam int T_HOLD      = 2;
  localparam int T_EXEC      = 10;
  localparam int T_EXEC_LONG = 40;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N  = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_rs    = 1'b0;
  logic [7:0] wr_data  = 8'h00;
  logic       wr_ready, init_done, LCD_ON, LCD_BLON, LCD_RW, LCD_EN, LCD_RS;
  logic [7:0] LCD_DATA;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         exp_lat;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] init_exp [6];
  logic [8:0] pulse_q [$];
  logic [8:0] exp_q [$];
  logic [8:0] hist [T_SETUP];
  logic [8:0] pulse_val = 9'h0;
  logic       prev_en   = 1'b0;
  int         hold_left = 0;
  int         rw_bad    = 0;

  lcd_ctrl #(
    .T_PWRUP     (T_PWRUP),
    .T_SETUP     (T_SETUP),
    .T_EN        (T_EN),
    .T_HOLD      (T_HOLD),
    .T_EXEC      (T_EXEC),
    .T_EXEC_LONG (T_EXEC_LONG)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .wr_valid (wr_valid),
    .wr_rs    (wr_rs),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .init_done(init_done),
    .LCD_ON   (LCD_ON),
    .LCD_BLON (LCD_BLON),
    .LCD_RW   (LCD_RW),
    .LCD_EN   (LCD_EN),
    .LCD_RS   (LCD_RS),
    .LCD_DATA (LCD_DATA)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // RS/DATA must match the pulsed value for T_SETUP samples before EN rises,
  // while EN is high, and for T_HOLD samples after it falls.
  task automatic monitor();
    logic [8:0] cur;
    cur = {LCD_RS, LCD_DATA};
    if (LCD_RW !== 1'b0) rw_bad++;
    if (!RESET_N) begin
      prev_en   = 1'b0;
      hold_left = 0;
    end else begin
      if (LCD_EN && !prev_en) begin
        pulse_q.push_back(cur);
        pulse_val = cur;
        for (int i = 0; i < T_SETUP; i++) check("setup_stable", int'(hist[i]), int'(cur));
      end else if (LCD_EN) begin
        check("pulse_stable", int'(cur), int'(pulse_val));
      end
      if (!LCD_EN && prev_en) hold_left = T_HOLD;
      if (hold_left > 0) begin
        check("hold_stable", int'(cur), int'(pulse_val));
        hold_left--;
      end
      prev_en = LCD_EN;
    end
    for (int i = T_SETUP - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = cur;
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
    monitor();
  endtask

  task automatic run_init(input string tag);
    int first_rise;
    int c;
    first_rise = -1;
    pulse_q.delete();
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    for (c = 0; c < 2000; c++) begin
      tick();
      if (LCD_EN && first_rise < 0) begin
        first_rise = c;
        check({tag, "_done_low_at_rise"}, int'(init_done), 0);
      end
      if (init_done) break;
    end
    check({tag, "_no_timeout"}, int'(c < 2000), 1);
    check({tag, "_first_en_clock"}, first_rise, 22);
    check({tag, "_pulse_count"}, pulse_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < pulse_q.size())
        check($sformatf("%s_cmd%0d", tag, i), int'(pulse_q[i]), int'({1'b0, init_exp[i]}));
    end
    check({tag, "_init_done"}, int'(init_done), 1);
    check({tag, "_ready"}, int'(wr_ready), 1);
    check({tag, "_lcd_on"}, int'(LCD_ON), 1);
    check({tag, "_lcd_blon"}, int'(LCD_BLON), 1);
  endtask

  task automatic do_write(input int idx, input logic rs, input logic [7:0] data,
                          input int exp_lat);
    int         k;
    int         rise;
    int         width;
    logic [8:0] seen;
    rise  = 0;
    width = 0;
    seen  = 9'h0;
    check($sformatf("v%0d_ready_before", idx), int'(wr_ready), 1);
    wr_valid = 1'b1;
    wr_rs    = rs;
    wr_data  = data;
    tick();
    k = 1;
    wr_valid = 1'b0;
    check($sformatf("v%0d_ready_low", idx), int'(wr_ready), 0);
    while (!wr_ready && k < 300) begin
      if (LCD_EN) begin
        if (rise == 0) begin
          rise = k;
          seen = {LCD_RS, LCD_DATA};
        end
        width++;
      end
      tick();
      k++;
    end
    check($sformatf("v%0d_ready_clock", idx), k, exp_lat);
    check($sformatf("v%0d_en_rise_clock", idx), rise, 3);
    check($sformatf("v%0d_en_width", idx), width, 4);
    check($sformatf("v%0d_rs_data", idx), int'(seen), int'({rs, data}));
  endtask

  initial begin
    int acc;
    int rdy_hi;
    int n;

    init_exp = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    // ready clock = 2 + 4 + 2 + exec + 1 ; exec = 40 for clear/home, else 10
    vecs[0] = '{1'b1, 8'h41, 19};
    vecs[1] = '{1'b0, 8'h01, 49};
    vecs[2] = '{1'b0, 8'h80, 19};
    vecs[3] = '{1'b0, 8'h02, 49};
    vecs[4] = '{1'b0, 8'h04, 19};
    vecs[5] = '{1'b1, 8'h01, 19};
    vecs[6] = '{1'b0, 8'h03, 49};
    vecs[7] = '{1'b1, 8'h00, 19};

    // Reset state
    RESET_N = 1'b0;
    repeat (3) tick();
    check("rst_en", int'(LCD_EN), 0);
    check("rst_rs", int'(LCD_RS), 0);
    check("rst_data", int'(LCD_DATA), 0);
    check("rst_on", int'(LCD_ON), 0);
    check("rst_blon", int'(LCD_BLON), 0);
    check("rst_ready", int'(wr_ready), 0);
    check("rst_init_done", int'(init_done), 0);

    run_init("init");

    for (int v = 0; v < 8; v++) do_write(v, vecs[v].rs, vecs[v].data, vecs[v].exp_lat);

    // Request held with changing data while busy: only bytes seen at ready are written
    pulse_q.delete();
    exp_q.delete();
    acc    = 0;
    rdy_hi = 0;
    n      = 0;
    while (n < 300 && !(acc == 3 && wr_ready)) begin
      if (wr_ready) rdy_hi++;
      if (acc < 3) begin
        wr_valid = 1'b1;
        wr_rs    = 1'b1;
        wr_data  = 8'h60 + 8'(n);
        if (wr_ready) begin
          exp_q.push_back({1'b1, wr_data});
          acc++;
        end
      end else begin
        wr_valid = 1'b0;
      end
      tick();
      n++;
    end
    wr_valid = 1'b0;
    check("busy_no_timeout", int'(n < 300), 1);
    check("busy_ready_samples", rdy_hi, 3);
    check("busy_pulse_count", pulse_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < pulse_q.size() && i < exp_q.size())
        check($sformatf("busy_byte%0d", i), int'(pulse_q[i]), int'(exp_q[i]));
    end

    // Reset asserted while EN is high
    wr_valid = 1'b1;
    wr_rs    = 1'b1;
    wr_data  = 8'h41;
    tick();
    wr_valid = 1'b0;
    for (int k = 0; k < 10 && !LCD_EN; k++) tick();
    check("midrst_in_pulse", int'(LCD_EN), 1);
    RESET_N = 1'b0;
    #1;
    check("midrst_en", int'(LCD_EN), 0);
    check("midrst_init_done", int'(init_done), 0);
    check("midrst_ready", int'(wr_ready), 0);
    check("midrst_data", int'(LCD_DATA), 0);
    check("midrst_on", int'(LCD_ON), 0);
    tick();
    tick();
    run_init("reinit");

    do_write(8, 1'b1, 8'h5A, 19);

    check("rw_always_low", rw_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
